// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, fetches one word per step over a
// valid/ready request channel and hands it to decode until execute supplies the next PC.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_data,
  input  logic             mem_rsp_err,
  output logic [31:0]      inst,
  output logic [31:0]      pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic             npc_valid,
  input  logic             npc_jump,
  input  logic [31:0]      npc_target,
  input  logic             halt,
  output logic             halted,
  output logic             fault,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    RSP   = 3'd2,
    HOLD  = 3'd3,
    NPC   = 3'd4,
    HALT  = 3'd5,
    FAULT = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
  logic [31:0]      jump_tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      fault_addr_q <= 32'h0;
      inst_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      fault_addr_q <= fault_addr_d;
      inst_cnt_q   <= inst_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    fault_addr_d = fault_addr_q;
    inst_cnt_d   = inst_cnt_q;
    // jalr clears bit 0; a remaining bit 1 means the target is not word aligned
    jump_tgt     = npc_target & ~32'h1;

    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (mem_req_ready) state_d = RSP;
      end
      RSP: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            fault_addr_d = pc_q;
            state_d      = FAULT;
          end else begin
            inst_d  = mem_rsp_data;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (inst_ready) begin
          inst_cnt_d = inst_cnt_q + CNT_ONE;
          state_d    = NPC;
        end
      end
      NPC: begin
        if (npc_valid) begin
          if (halt) begin
            state_d = HALT;
          end else if (npc_jump) begin
            if (jump_tgt[1]) begin
              fault_addr_d = jump_tgt;
              state_d      = FAULT;
            end else begin
              pc_d    = jump_tgt;
              state_d = REQ;
            end
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = REQ;
          end
        end
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = pc_q;
  assign inst_valid    = (state_q == HOLD);
  assign halted        = (state_q == HALT);
  assign fault         = (state_q == FAULT);
  assign inst          = inst_q;
  assign pc            = pc_q;
  assign fault_addr    = fault_addr_q;
  assign inst_cnt      = inst_cnt_q;

endmodule
